// File: rtl/sayac_arb_mux.sv
// sayac_arb_mux: registered CH-way arbitrating mux with a valid/ready output.
// Fixed priority (MODE=0, channel 0 highest) or round-robin (MODE=1) select.
// The winning channel's word is captured into outMUX. gnt is combinational
// and one-hot, so each source sees its acknowledge in the capture cycle.
module sayac_arb_mux #(
    parameter int N    = 16,
    parameter int CH   = 4,
    parameter int MODE = 0,
    parameter int SW   = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   req,
    input  logic [CH*N-1:0] inData,
    output logic [CH-1:0]   gnt,
    output logic [N-1:0]    outMUX,
    output logic            outValid,
    input  logic            outReady,
    output logic [SW-1:0]   outSrc
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] start;
    logic [SW-1:0] win;
    logic [SW-1:0] ptr_nxt;
    logic          found;
    logic          load;
    int            idx;

    // Scan origin: fixed priority always starts at channel 0.
    always_comb begin
        start = (MODE == 1) ? ptr : '0;
    end

    // Pick the first requesting channel scanning upward from start, with wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < CH; k++) begin
            idx = int'(start) + k;
            if (idx >= CH) idx = idx - CH;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end
    end

    // Load when something is requesting and the output slot is free or being
    // drained this cycle. Reset suppresses grants so no word is lost.
    always_comb begin
        load    = found & (~outValid | outReady) & ~rst;
        gnt     = load ? (CH'(1) << win) : '0;
        ptr_nxt = (win == SW'(CH - 1)) ? '0 : win + SW'(1);
    end

    // Output register, valid flag and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            outMUX   <= '0;
            outSrc   <= '0;
            outValid <= 1'b0;
            ptr      <= '0;
        end else if (load) begin
            outMUX   <= inData[int'(win)*N +: N];
            outSrc   <= win;
            outValid <= 1'b1;
            if (MODE == 1) ptr <= ptr_nxt;
        end else if (outValid && outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sayac_arb_mux.sv
// Bench for sayac_arb_mux: fixed-priority and round-robin instances share
// stimulus. A behavioural model checks both every cycle; a hand-derived table
// and directed sequences cover reset, stall, drain and rotation corners.
module tb_sayac_arb_mux;

    localparam int N  = 16;
    localparam int CH = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   req = '0;
    logic [CH*N-1:0] inData = '0;
    logic            outReady = 1'b0;

    logic [CH-1:0] gnt0, gnt1;
    logic [N-1:0]  mux0, mux1;
    logic          v0, v1;
    logic [SW-1:0] src0, src1;

    sayac_arb_mux #(.N(N), .CH(CH), .MODE(0)) u_fix (
        .clk(clk), .rst(rst), .req(req), .inData(inData), .gnt(gnt0),
        .outMUX(mux0), .outValid(v0), .outReady(outReady), .outSrc(src0)
    );

    sayac_arb_mux #(.N(N), .CH(CH), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .req(req), .inData(inData), .gnt(gnt1),
        .outMUX(mux1), .outValid(v1), .outReady(outReady), .outSrc(src1)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nbad = 0;

    // Behavioural model state, index 0 = fixed, 1 = round-robin.
    logic        mv   [2];
    logic [15:0] mmux [2];
    int          msrc [2];
    int          mptr [2];

    logic [3:0] g0_pre, g1_pre;

    localparam logic [63:0] D = {16'h3333, 16'h1234, 16'hAAAA, 16'h1000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Winner per the policy: first requester in the order start, start+1, ...
    function automatic int model_win(input int mode, input logic [3:0] r, input int p);
        int s;
        s = (mode == 1) ? p : 0;
        for (int k = 0; k < CH; k++)
            if (r[(s + k) % CH]) return (s + k) % CH;
        return -1;
    endfunction

    // One clock: drive at negedge, check gnt mid-cycle, check registers after edge.
    task automatic step(input logic r_rst, input logic [3:0] r_req, input logic rdy,
                        input logic [63:0] d);
        int         w;
        logic       ld;
        logic [3:0] eg;
        rst = r_rst; req = r_req; outReady = rdy; inData = d;
        #1;
        g0_pre = gnt0;
        g1_pre = gnt1;
        for (int m = 0; m < 2; m++) begin
            w  = model_win(m, r_req, mptr[m]);
            ld = !r_rst && (w >= 0) && (!mv[m] || rdy);
            eg = ld ? 4'(1 << w) : 4'h0;
            chk(m == 0 ? "gnt_fix" : "gnt_rr", m == 0 ? gnt0 : gnt1, eg);
            if (r_rst) begin
                mv[m] = 1'b0; mmux[m] = '0; msrc[m] = 0; mptr[m] = 0;
            end else if (ld) begin
                mv[m] = 1'b1; mmux[m] = d[w*16 +: 16]; msrc[m] = w;
                if (m == 1) mptr[m] = (w + 1) % CH;
            end else if (mv[m] && rdy) begin
                mv[m] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("valid_fix", v0, mv[0]);
        chk("data_fix", mux0, mmux[0]);
        chk("src_fix", src0, msrc[0]);
        chk("valid_rr", v1, mv[1]);
        chk("data_rr", mux1, mmux[1]);
        chk("src_rr", src1, msrc[1]);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        rdy;
        logic [3:0]  gnt;
        logic        v;
        logic [15:0] mux;
        logic [1:0]  src;
    } vec_t;

    vec_t tbl[16];
    int   rr_exp[6];

    initial begin
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0; mmux[m] = '0; msrc[m] = 0; mptr[m] = 0;
        end

        // Hand-derived expectations for the fixed-priority instance.
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
        tbl[2]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 16'hAAAA, 2'd1};
        tbl[3]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 16'hAAAA, 2'd1};
        tbl[4]  = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 16'h3333, 2'd3};
        tbl[5]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'h1234, 2'd2};
        tbl[6]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 16'h1234, 2'd2};
        tbl[7]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 16'h1234, 2'd2};
        tbl[8]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 16'h1234, 2'd2};
        tbl[9]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 16'h1000, 2'd0};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h1000, 2'd0};
        tbl[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'h1000, 2'd0};
        tbl[12] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 16'hAAAA, 2'd1};
        tbl[13] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'hAAAA, 2'd1};
        tbl[14] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 16'h0000, 2'd0};
        tbl[15] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 16'h1000, 2'd0};

        rr_exp = '{0, 1, 2, 3, 0, 1};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].rdy, D);
            chk($sformatf("tbl%0d_gnt", i), g0_pre, tbl[i].gnt);
            chk($sformatf("tbl%0d_valid", i), v0, tbl[i].v);
            chk($sformatf("tbl%0d_data", i), mux0, tbl[i].mux);
            chk($sformatf("tbl%0d_src", i), src0, tbl[i].src);
        end

        // Round-robin rotation from reset with all channels requesting.
        step(1'b1, 4'b1111, 1'b1, D);
        step(1'b1, 4'b1111, 1'b1, D);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b1111, 1'b1, D);
            if (i == 0) begin
                chk("first_gnt_fix", g0_pre, 4'b0001);
                chk("first_gnt_rr", g1_pre, 4'b0001);
            end
            chk($sformatf("rr_src%0d", i), src1, rr_exp[i]);
            chk($sformatf("rr_valid%0d", i), v1, 1'b1);
        end

        // Drain with no requests: valid drops, data held, pointer held at 2.
        step(1'b0, 4'b0000, 1'b1, D);
        chk("drain_valid", v1, 1'b0);
        chk("drain_data", mux1, 16'hAAAA);
        step(1'b0, 4'b0000, 1'b1, D);
        step(1'b0, 4'b1111, 1'b1, D);
        chk("rr_after_idle", g1_pre, 4'b0100);

        // Reset during a stall discards the word and rewinds the pointer.
        step(1'b0, 4'b0000, 1'b0, D);
        step(1'b1, 4'b1111, 1'b0, D);
        chk("rst_stall_gnt", g1_pre, 4'b0000);
        chk("rst_stall_valid", v1, 1'b0);
        chk("rst_stall_data", mux1, 16'h0000);
        step(1'b0, 4'b1111, 1'b0, D);
        chk("rst_stall_ptr", g1_pre, 4'b0001);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            step(($urandom_range(0, 49) == 0), r, 1'($urandom_range(0, 3) != 0),
                 {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/sayac_arb_mux.md
Name: sayac_arb_mux

Overview:
- Parametrised, registered, multi-channel successor to the SAYAC 2-input priority select mux.
- Arbitrates among CH requesting sources, each N bits wide, and captures the winner's word into an output register.
- Output uses a valid/ready handshake, so a stalled consumer back-pressures all sources.
- Used wherever several SAYAC datapath units (register file, ALU, memory interface, immediate path) share one bus.

Parameters:
- N, 16, data width in bits per channel.
- CH, 4, number of input channels; legal range 2..16.
- MODE, 0, arbitration policy: 0 = fixed priority (channel 0 highest), 1 = round-robin.
- SW, $clog2(CH), width of the source-index output. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  CH  per-channel request; bit i set means channel i has valid data.
- inData  input  CH*N  flattened channel data; channel i occupies bits [i*N +: N].
- gnt  output  CH  one-hot acknowledge, combinational. Bit i high in the cycle channel i's data is captured.
- outMUX  output  N  registered selected data.
- outValid  output  1  outMUX holds an unconsumed word.
- outReady  input  1  consumer accepts outMUX this cycle.
- outSrc  output  SW  channel index of the word in outMUX.

Behaviour:
- Reset: on a rising clk edge with rst=1, outMUX=0, outValid=0, outSrc=0, and the round-robin pointer = 0. gnt=0 while rst=1. rst dominates all other inputs.
- load = (|req) & (~outValid | outReady). gnt is nonzero only when load=1.
- Fixed mode (MODE=0): the winner is the lowest-index asserted req bit.
- Round-robin mode (MODE=1): the winner is the first asserted req bit scanning upward from ptr, wrapping from CH-1 to 0. On every load, ptr <= winner+1, wrapping to 0 after CH-1. ptr does not change when load=0.
- On a load edge:
  - outMUX <= channel winner data.
  - outSrc <= winner.
  - outValid <= 1.
- Pop without load (outValid & outReady & ~|req): outValid <= 0. outMUX and outSrc hold their last values.
- Stall (outValid & ~outReady): outMUX, outSrc, outValid and ptr all hold. gnt=0.
- Latency: data presented with req in cycle t is visible on outMUX in cycle t+1.
- Throughput: one word per cycle when outReady is held high.
- Source protocol: a source holds req and its data until it sees its gnt bit. It may deassert req in the cycle after gnt, or keep req high to send another word.
- Simultaneous pop and load: both take effect in the same cycle, outValid stays 1, and no bubble is inserted.
- Mid-operation reset: a pending output word is discarded. No gnt is issued in the reset cycle.
- req=0: gnt=0, nothing is loaded, and the round-robin pointer holds.
- gnt is a pure function of req, outValid, outReady and ptr. It contains no combinational path from inData.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=4'b1111 -> gnt=0, outValid=0, outMUX=0, outSrc=0. After rst drops, the first cycle gives gnt=4'b0001 (both modes, since ptr=0).
- Fixed priority, N=16, CH=4: req=4'b1010, ch1=16'hAAAA, ch3=16'h3333, outReady=1 -> gnt=4'b0010. Next cycle outMUX=16'hAAAA, outSrc=1. Channel 3 keeps winning only after req[1] drops.
- Round-robin, MODE=1: req=4'b1111 held, outReady=1 for 6 cycles -> outSrc sequence 0,1,2,3,0,1, with outValid continuously 1.
- Back-pressure: load ch2=16'h1234, then outReady=0 for 3 cycles with req=4'b0001 -> outMUX stays 16'h1234 and gnt=0. When outReady=1, ch0 is granted that cycle and outMUX=ch0 data on the next cycle.
- Drain and hold: outValid=1, outReady=1, req=0 -> outValid goes 0 next cycle while outMUX retains its value. With req=0 continued, the round-robin pointer is unchanged (verify via the next grant order).
- Reset mid-stall: outValid=1, outReady=0, assert rst for 1 cycle -> outValid=0, outMUX=0, and the round-robin pointer returns to 0.
